// File: rtl/spike_event_queue.sv
// Rising-edge spike capture with timestamp tagging, lowest-index-first arbitration into a FIFO.
// Optional saturating drop counter and drop_count port when EVT_DROP_CNT_EN is defined.
module spike_event_queue #(
  parameter int NUM_NEURONS = 4,
  parameter int ID_W        = 2,
  parameter int TS_W        = 8,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [TS_W+ID_W-1:0]   evt_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
`ifdef EVT_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]       drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TS_W-1:0]        ts;
  logic [NUM_NEURONS-1:0] prev_spike;
  logic [NUM_NEURONS-1:0] pending;
  logic [TS_W-1:0]        ts_lat [NUM_NEURONS];
  logic [TS_W+ID_W-1:0]   mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;

  logic                   sel_valid;
  logic [ID_W-1:0]        sel_idx;
  logic                   push;
  logic                   pop;
  logic [NUM_NEURONS-1:0] clr;
  logic [NUM_NEURONS-1:0] cap;
  logic [NUM_NEURONS-1:0] drop;
  logic [NUM_NEURONS-1:0] accept;

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      if (pending[i] && !sel_valid) begin
        sel_valid = 1'b1;
        sel_idx   = ID_W'(i);
      end
    end
  end

  // A neuron whose pending event is pushed this edge may accept a new rise in the same edge.
  always_comb begin
    push = sel_valid && (count != CW'(DEPTH));
    pop  = (count != '0) && evt_ready;
    clr  = '0;
    if (push) clr[sel_idx] = 1'b1;
    cap    = enable ? (spike_in & ~prev_spike) : '0;
    drop   = cap & pending & ~clr;
    accept = cap & ~drop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ts         <= '0;
      prev_spike <= '0;
      pending    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) ts_lat[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (enable) ts <= ts + TS_W'(1);
      prev_spike <= spike_in;
      pending    <= (pending & ~clr) | accept;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        if (accept[i]) ts_lat[i] <= ts;
      end
      if (push) begin
        mem[wr_ptr] <= {ts_lat[sel_idx], sel_idx};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (|drop) overflow <= 1'b1;
    end
  end

`ifdef EVT_DROP_CNT_EN
  localparam int SW = CNT_W + ID_W + 1;

  logic [ID_W:0]    n_drop;
  logic [SW-1:0]    drop_sum;

  always_comb begin
    n_drop = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) n_drop = n_drop + (ID_W+1)'(drop[i]);
    drop_sum = SW'(drop_count) + SW'(n_drop);
  end

  always_ff @(posedge clk) begin
    if (!rst)                                drop_count <= '0;
    else if (drop_sum > SW'({CNT_W{1'b1}}))  drop_count <= '1;
    else                                     drop_count <= drop_sum[CNT_W-1:0];
  end
`endif

  assign evt_valid  = (count != '0);
  assign evt_data   = mem[rd_ptr];
  assign fifo_count = count;

endmodule

// File: tb/tb_spike_event_queue.sv
// Directed and randomized bench for spike_event_queue against a queue-based event model.
// Drop counter checks are included when EVT_DROP_CNT_EN is defined.
module tb_spike_event_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] spike_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [9:0] evt_data;
  logic [3:0] fifo_count;
  logic       overflow;
`ifdef EVT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  int unsigned m_ts;
  bit          m_prev [4];
  bit          m_pend [4];
  int unsigned m_lat  [4];
  int unsigned q [$];
  bit          m_ovf;
  int unsigned m_drops;

  spike_event_queue #(
    .NUM_NEURONS(4),
    .ID_W(2),
    .TS_W(8),
    .DEPTH(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .spike_in(spike_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data(evt_data),
    .fifo_count(fifo_count),
    .overflow(overflow)
`ifdef EVT_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] sp, input logic en, input logic rdy, input logic rs);
    int          pushed;
    int unsigned entry;
    int unsigned sz;
    if (!rs) begin
      m_ts = 0; q.delete(); m_ovf = 0; m_drops = 0;
      for (int i = 0; i < 4; i++) begin m_prev[i] = 0; m_pend[i] = 0; m_lat[i] = 0; end
      return;
    end
    sz = q.size();
    pushed = -1;
    entry = 0;
    if (sz < 8) begin
      for (int i = 0; i < 4; i++) if (m_pend[i] && pushed < 0) pushed = i;
    end
    if (pushed >= 0) entry = m_lat[pushed] * 4 + pushed;
    if (sz > 0 && rdy) void'(q.pop_front());
    if (pushed >= 0) begin
      q.push_back(entry);
      m_pend[pushed] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (en && sp[i] && !m_prev[i]) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1;
          m_lat[i]  = m_ts;
        end else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      m_prev[i] = sp[i];
    end
    if (en) m_ts = (m_ts + 1) % 256;
  endtask

  task automatic compare_all();
    check("valid", 32'(evt_valid), 32'(q.size() != 0));
    check("count", 32'(fifo_count), q.size());
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) check("data", 32'(evt_data), q[0]);
`ifdef EVT_DROP_CNT_EN
    check("drop_count", 32'(drop_count), m_drops);
`endif
  endtask

  task automatic tick(input logic [3:0] sp, input logic en, input logic rdy, input logic rs);
    spike_in  = sp;
    enable    = en;
    evt_ready = rdy;
    rst       = rs;
    @(posedge clk);
    model_step(sp, en, rdy, rs);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] sp;
    logic       en;
    logic       rdy;
    logic       rs;

    // 1: reset
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_data", 32'(evt_data), 0);

    // 2: single event at ts=5
    for (int i = 0; i < 5; i++) tick(4'b0000, 1'b1, 1'b1, 1'b1);
    tick(4'b0100, 1'b1, 1'b1, 1'b1);
    check("single_lat_valid", 32'(evt_valid), 0);
    tick(4'b0100, 1'b1, 1'b1, 1'b1);
    check("single_valid", 32'(evt_valid), 1);
    check("single_data", 32'(evt_data), 5 * 4 + 2);
    for (int i = 0; i < 9; i++) tick(4'b0100, 1'b1, 1'b1, 1'b1);
    check("single_once", 32'(fifo_count), 0);

    // 3: simultaneous rise at ts=9
    tick(4'b0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) tick(4'b0000, 1'b1, 1'b1, 1'b1);
    tick(4'b1011, 1'b1, 1'b1, 1'b1);
    tick(4'b1011, 1'b1, 1'b1, 1'b1);
    check("simul_beat0", 32'(evt_data), 9 * 4 + 0);
    tick(4'b1011, 1'b1, 1'b1, 1'b1);
    check("simul_beat1", 32'(evt_data), 9 * 4 + 1);
    tick(4'b1011, 1'b1, 1'b1, 1'b1);
    check("simul_beat3", 32'(evt_data), 9 * 4 + 3);
    tick(4'b0000, 1'b1, 1'b1, 1'b1);
    tick(4'b0000, 1'b1, 1'b1, 1'b1);

    // 4: backpressure, full FIFO, pending 9th, same-neuron drop
    for (int r = 0; r < 8; r++) begin
      sp = 4'b0001 << (r % 4);
      tick(sp, 1'b1, 1'b0, 1'b1);
      tick(4'b0000, 1'b1, 1'b0, 1'b1);
    end
    check("bp_full", 32'(fifo_count), 8);
    tick(4'b0001, 1'b1, 1'b0, 1'b1);
    tick(4'b0000, 1'b1, 1'b0, 1'b1);
    check("bp_hold", 32'(fifo_count), 8);
    tick(4'b0001, 1'b1, 1'b0, 1'b1);
    check("bp_ovf", 32'(overflow), 1);
`ifdef EVT_DROP_CNT_EN
    check("bp_drop1", 32'(drop_count), 1);
`endif
    for (int i = 0; i < 11; i++) tick(4'b0000, 1'b1, 1'b1, 1'b1);
    check("bp_drained", 32'(fifo_count), 0);

    // 5: timestamp wrap and pointer wrap
    tick(4'b0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) tick(4'b0000, 1'b1, 1'b1, 1'b1);
    tick(4'b0001, 1'b1, 1'b1, 1'b1);
    tick(4'b0000, 1'b1, 1'b1, 1'b1);
    check("wrap_ts255", 32'(evt_data), 255 * 4);
    tick(4'b0001, 1'b1, 1'b1, 1'b1);
    tick(4'b0000, 1'b1, 1'b1, 1'b1);
    check("wrap_ts1", 32'(evt_data), 1 * 4);
    tick(4'b0000, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 8; r++) begin
        sp = 4'b0001 << ((r + k) % 4);
        tick(sp, 1'b1, 1'b0, 1'b1);
        tick(4'b0000, 1'b1, 1'b0, 1'b1);
      end
      check("fill_count", 32'(fifo_count), 8);
      for (int i = 0; i < 9; i++) tick(4'b0000, 1'b1, 1'b1, 1'b1);
      check("drain_count", 32'(fifo_count), 0);
    end

    // 6: reset with queued and pending events
    for (int r = 0; r < 3; r++) begin
      tick(4'b0001 << r, 1'b1, 1'b0, 1'b1);
      tick(4'b0000, 1'b1, 1'b0, 1'b1);
    end
    tick(4'b1111, 1'b1, 1'b0, 1'b1);
    tick(4'b1111, 1'b1, 1'b0, 1'b1);
    tick(4'b1111, 1'b1, 1'b0, 1'b1);
    check("mid_count5", 32'(fifo_count), 5);
    tick(4'b1111, 1'b1, 1'b0, 1'b0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_valid", 32'(evt_valid), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) tick(4'b1111, 1'b1, 1'b1, 1'b1);

    // randomized traffic
    sp = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) < 3) sp[b] = ~sp[b];
      en  = ($urandom_range(0, 9) != 0);
      rdy = (n % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 499) != 0);
      tick(sp, en, rdy, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
